// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, instruction kinds,
// legal R-type function codes and the load-session FSM states.
package instr_encoder_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;

  typedef enum logic [1:0] {
    KIND_R   = 2'd0,
    KIND_LW  = 2'd1,
    KIND_SW  = 2'd2,
    KIND_BEQ = 2'd3
  } kind_t;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: assembles a 32-bit MIPS word from the decoded
// instruction fields. I-types ignore rd, shamt and funct.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = {OP_R, rs, rt, rd, shamt, funct};
    case (kind_t'(kind))
      KIND_LW:  word = {OP_LW, rs, rt, imm};
      KIND_SW:  word = {OP_SW, rs, rt, imm};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
      default:  word = {OP_R, rs, rt, rd, shamt, funct};
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts instruction fields in a load session and writes
// encoded words to instruction memory one cycle later. Illegal-funct checking
// is enabled with `define ENCODER_CHECK_EN.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready;
// in_ready is high exactly while the FSM is in LOAD and in_valid may be held.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          err,
  output state_t        state
);

  state_t        state_next;
  logic [AW-1:0] ptr;
  logic [31:0]   word;
  logic          accept;
  logic          write;
  logic          last;
  logic          done_next;

  instr_pack u_pack (
    .kind  (in_kind),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .funct (in_funct),
    .imm   (in_imm),
    .word  (word)
  );

  assign in_ready = (state == ST_LOAD);
  assign full     = (state == ST_FULL);
  assign accept   = in_valid && in_ready;
  assign last     = (ptr == AW'(DEPTH - 1));

`ifdef ENCODER_CHECK_EN
  logic legal;
  logic err_q;
  assign legal = (kind_t'(in_kind) != KIND_R) || funct_legal(in_funct);
  assign write = accept && legal;
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
    end
  end
`else
  assign write = accept;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (start) begin
          state_next = ST_LOAD;
        end else if (stop) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (write && last) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (start) begin
          state_next = ST_LOAD;
        end else if (stop) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A word accepted alongside start still lands at the old pointer; the new
  // session then begins at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      mem_we <= write;
      done   <= done_next;
      if (write) begin
        mem_addr  <= ptr;
        mem_wdata <= word;
      end
      if (start) begin
        ptr   <= '0;
        count <= '0;
      end else if (write) begin
        ptr   <= last ? ptr : ptr + AW'(1);
        count <= count + (AW + 1)'(1);
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory depth in 32-bit words; power of two, at least 4.
REQ-002 Parameter AW, default 6: word-address width, equal to log2(DEPTH).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  pulse; begins a load session at word address 0.
REQ-006 stop  in  1  pulse; ends the load session.
REQ-007 in_valid  in  1  instruction fields are presented.
REQ-008 in_ready  out  1  encoder accepts fields this cycle.
REQ-009 in_kind  in  2  instruction class: 0=R-type, 1=lw, 2=sw, 3=beq.
REQ-010 in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-011 in_funct  in  6  R-type function code.
REQ-012 in_imm  in  16  immediate or branch offset.
REQ-013 mem_we  out  1  instruction-memory write strobe.
REQ-014 mem_addr  out  AW  word address of the write.
REQ-015 mem_wdata  out  32  encoded instruction word.
REQ-016 count  out  AW+1  number of words written in the current session.
REQ-017 full  out  1  memory is full; high in FULL state.
REQ-018 done  out  1  one-cycle pulse when a session ends through stop.
REQ-019 err  out  1  sticky illegal-instruction flag; present only with ENCODER_CHECK_EN.

Function
REQ-020 The FSM SHALL have three states: IDLE, LOAD and FULL.
REQ-021 IDLE: in_ready=0; start moves the FSM to LOAD and clears the write pointer and count to 0.
REQ-022 LOAD: in_ready=1; a handshake (in_valid & in_ready) accepts one instruction per cycle.
REQ-023 Each instruction accepted in cycle N SHALL be written in cycle N+1: mem_we=1, mem_addr=pointer, mem_wdata=encoded word (1-cycle registered latency, full throughput).
REQ-024 After every write, the pointer and count SHALL each increment by 1.
REQ-025 Encoding of an R-type instruction: {6'b000000, rs, rt, rd, shamt, funct}.
REQ-026 Encoding of lw: {6'b100011, rs, rt, imm}.
REQ-027 Encoding of sw: {6'b101011, rs, rt, imm}.
REQ-028 Encoding of beq: {6'b000100, rs, rt, imm}.
REQ-029 For I-types, rd, shamt and funct SHALL be ignored.
REQ-030 When the instruction for address DEPTH-1 is accepted, the FSM SHALL enter FULL and drop in_ready in the next cycle; the pointer SHALL NOT wrap.
REQ-031 FULL: full=1, in_ready=0. start re-enters LOAD from address 0. stop returns to IDLE and pulses done.
REQ-032 stop in LOAD SHALL move the FSM to IDLE and pulse done one cycle later. An instruction accepted in the same cycle as stop is still written.
REQ-033 start in LOAD SHALL restart the session: pointer=0 and count=0. A write pending from the previous cycle completes at its old address.
REQ-034 If start and stop are asserted together, start SHALL win.
REQ-035 Outside a write cycle, mem_we=0 and mem_wdata/mem_addr SHALL hold their last values.

Reset
REQ-036 When rst is high at a clock edge, the FSM SHALL go to IDLE and in_ready, mem_we, full, done and err SHALL be 0, with mem_addr, mem_wdata and count at 0.
REQ-037 Reset during LOAD SHALL discard any pending write; mem_we=0 in the cycle after reset.

Configuration
REQ-038 With ENCODER_CHECK_EN defined, an R-type instruction whose funct is not one of 0x20, 0x22, 0x24, 0x25 or 0x2A SHALL be accepted but not written: no pointer or count change, and err set sticky until start or rst.
REQ-039 Without ENCODER_CHECK_EN, every funct SHALL be encoded and written, and err SHALL be tied to 0.

Structure
REQ-040 A shared package SHALL hold the opcode constants (R=0, LW=0x23, SW=0x2B, BEQ=0x04), the in_kind enumeration, the legal funct constants and the FSM state typedef.
REQ-041 The combinational field packer SHALL be a separate sub-module instr_pack; the FSM, pointer and output registers SHALL stay in instr_encoder.

Verification
REQ-042 rst, start, then R-type rs=1 rt=2 rd=3 funct=0x20 -> next cycle mem_we=1, addr=0, wdata=0x00221820, count=1.
REQ-043 lw rs=0 rt=8 imm=0x0004, then sw rs=0 rt=8 imm=0x0008 back-to-back -> 0x8C080004 written at addr 0 and 0xAC080008 at addr 1, in consecutive cycles.
REQ-044 beq rs=4 rt=5 imm=0xFFFF -> wdata=0x1085FFFF.
REQ-045 64 instructions streamed with DEPTH=64 -> full=1 and in_ready=0 after the last write, count=64, no write to addr 0.
REQ-046 Instruction accepted together with stop -> the instruction is written, done pulses one cycle later, FSM in IDLE.
REQ-047 With ENCODER_CHECK_EN, R-type funct=0x3F -> no write, err=1, count unchanged. Rerun without the macro -> 0x...3F written and err=0.
